// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_if
//  Description : Load/store request/response bundle between a processor data
//                port (master) and the data-memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-outstanding word load/store responder with a
//                programmable number of wait states, address fault checking
//                and a 2**AW_WORDS x 32 on-chip RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int AW_WORDS = 6,
    parameter int WAIT     = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    dmem_responder_if.slave  bus
);

    localparam int c_DEPTH = 1 << AW_WORDS;
    localparam int c_CW    = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [c_CW-1:0] c_WAIT_LD = c_CW'(WAIT);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CW-1:0]     r_cnt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_ready;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [c_DEPTH];

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_we;
    logic [31:0]         w_addr;
    logic [31:0]         w_wdata;
    logic                w_fault;
    logic [AW_WORDS-1:0] w_idx;
    logic [31:0]         w_rd_val;
    logic                w_mem_wr;

    assign w_accept = (r_state == ST_IDLE) && bus.req;

    // With zero wait states the response is entered straight from IDLE on the
    // accepting edge; otherwise only from the last WAIT cycle.
    assign w_enter_resp = (WAIT == 0) ? w_accept
                                      : ((r_state == ST_WAIT) && (r_cnt == c_ONE));

    // On the accepting edge the capture registers are not loaded yet, so the
    // access fields come from the bus; in every other state from the capture.
    assign w_we    = (r_state == ST_IDLE) ? bus.we    : r_we;
    assign w_addr  = (r_state == ST_IDLE) ? bus.addr  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? bus.wdata : r_wdata;

    assign w_fault  = (w_addr[1:0] != 2'b00) || (|w_addr[31:AW_WORDS+2]);
    assign w_idx    = w_addr[AW_WORDS+1:2];
    assign w_rd_val = (!w_we && !w_fault) ? r_mem[w_idx] : 32'h0;

    // Gating with reset keeps an in-reset request from touching the RAM.
    assign w_mem_wr = w_enter_resp && w_we && !w_fault && reset;

    // Request FSM: capture, wait-state countdown and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_fault;
                r_rdata <= w_rd_val;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        if (WAIT == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_cnt   <= c_WAIT_LD;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == c_ONE) begin
                        r_cnt   <= '0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Word RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;
    assign bus.busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire
